// File: rtl/datamem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
// Holds the FSM state encoding and the port index constants.
package datamem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADDR   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic PORT_CPU  = 1'b0;
   localparam logic PORT_DISP = 1'b1;

   function automatic logic [1:0] port_mask(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/datamem_arb_rr.sv
// Two-way request picker: round-robin on last-served, or fixed
// priority with port 0 on top. Masked requests cannot win.
module datamem_arb_rr
   import datamem_arb_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic [1:0] i_req,
   input  logic       i_last,
   input  logic [1:0] i_mask,
   output logic       o_gnt,
   output logic       o_valid
);

   logic [1:0] w_elig;
   logic       w_top;

   always_comb begin
      w_elig  = i_req & ~i_mask;
      w_top   = i_req[0] ? PORT_CPU : PORT_DISP;
      o_gnt   = PORT_CPU;
      o_valid = 1'b0;
      if (FIXED_PRIO != 0) begin
         // A masked CPU still outranks the display, so the CPU is
         // picked up again from IDLE and the display may starve.
         o_gnt   = w_top;
         o_valid = (|i_req) && !i_mask[w_top];
      end else begin
         o_gnt   = (&w_elig) ? ~i_last : w_elig[1];
         o_valid = |w_elig;
      end
   end

endmodule

// File: rtl/datamem_arb.sv
// Arbitrates CPU and display-scanner access to a shared data memory
// through an IDLE -> ADDR -> ACCESS -> DONE Moore sequence.
module datamem_arb
   import datamem_arb_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p1_req,
   input  logic              p0_we,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p0_ack,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p0_rdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [DATA_W-1:0] mem_wbus,
   input  logic [DATA_W-1:0] mem_rbus,
   output logic              c_memaddr,
   output logic              c_dataread,
   output logic              c_datawrite,
   output logic              busy,
   output logic              gnt_id
);

   state_t            r_state;
   state_t            w_next;
   logic              r_gnt;
   logic              r_we;
   logic              r_last;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rd0;
   logic [DATA_W-1:0] r_rd1;
   logic              w_arb;
   logic              w_win;
   logic              w_valid;
   logic [1:0]        w_mask;

   assign w_arb  = (r_state == IDLE) || (r_state == DONE);
   // The port being acked may still hold req; keep it out this cycle.
   assign w_mask = (r_state == DONE) ? port_mask(r_gnt) : 2'b00;

   datamem_arb_rr #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_rr (
      .i_req   ({p1_req, p0_req}),
      .i_last  (r_last),
      .i_mask  (w_mask),
      .o_gnt   (w_win),
      .o_valid (w_valid)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:   w_next = w_valid ? ADDR : IDLE;
         ADDR:   w_next = ACCESS;
         ACCESS: w_next = DONE;
         DONE:   w_next = w_valid ? ADDR : IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_gnt   <= PORT_CPU;
         r_last  <= PORT_DISP;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rd0   <= '0;
         r_rd1   <= '0;
      end else begin
         r_state <= w_next;
         if (w_arb && w_valid) begin
            r_gnt   <= w_win;
            r_last  <= w_win;
            r_we    <= w_win ? p1_we    : p0_we;
            r_addr  <= w_win ? p1_addr  : p0_addr;
            r_wdata <= w_win ? p1_wdata : p0_wdata;
         end
         if ((r_state == ACCESS) && !r_we) begin
            if (r_gnt == PORT_DISP) r_rd1 <= mem_rbus;
            else                    r_rd0 <= mem_rbus;
         end
      end
   end

   always_comb begin
      c_memaddr   = 1'b0;
      c_dataread  = 1'b0;
      c_datawrite = 1'b0;
      mem_wbus    = '0;
      unique case (r_state)
         ADDR: begin
            c_memaddr = 1'b1;
            mem_wbus  = DATA_W'(r_addr);
         end
         ACCESS: begin
            c_datawrite = r_we;
            c_dataread  = ~r_we;
            mem_wbus    = r_we ? r_wdata : '0;
         end
         default: begin
         end
      endcase
   end

   assign busy     = (r_state != IDLE);
   assign gnt_id   = busy & r_gnt;
   assign p0_ack   = (r_state == DONE) && (r_gnt == PORT_CPU);
   assign p1_ack   = (r_state == DONE) && (r_gnt == PORT_DISP);
   assign p0_rdata = r_rd0;
   assign p1_rdata = r_rd1;

endmodule

// File: tb/tb_datamem_arb.sv
// Bench for datamem_arb: directed scenarios plus random traffic,
// checked against a transaction-age reference model.
module tb_datamem_arb;

   logic       clk = 1'b0;
   logic       reset;
   logic       p0_req, p1_req, p0_we, p1_we;
   logic [7:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
   logic       p0_ack, p1_ack;
   logic [7:0] p0_rdata, p1_rdata, mem_wbus, mem_rbus;
   logic       c_memaddr, c_dataread, c_datawrite, busy, gnt_id;

   logic       b0_req, b1_req, b0_ack, b1_ack;
   logic [7:0] b0_rdata, b1_rdata, b_wbus;
   logic       b_ma, b_dr, b_dw, b_busy, b_gnt;

   logic [7:0] env_mem [0:255];
   logic [7:0] env_a;

   int checks = 0;
   int failures = 0;

   bit         m_have;
   int         m_g;
   int         k;
   logic       m_port, m_we, m_last;
   logic [7:0] m_addr, m_wdata, m_rd0, m_rd1;
   logic [7:0] ref_mem [0:255];
   logic [1:0] pa_ack, pb_ack;
   int         nb0, nb1;

   always #5 clk = ~clk;

   datamem_arb #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p1_req(p1_req),
      .p0_we(p0_we), .p1_we(p1_we),
      .p0_addr(p0_addr), .p1_addr(p1_addr),
      .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
      .p0_ack(p0_ack), .p1_ack(p1_ack),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .mem_wbus(mem_wbus), .mem_rbus(mem_rbus),
      .c_memaddr(c_memaddr), .c_dataread(c_dataread),
      .c_datawrite(c_datawrite),
      .busy(busy), .gnt_id(gnt_id)
   );

   datamem_arb #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_fix (
      .clk(clk), .reset(reset),
      .p0_req(b0_req), .p1_req(b1_req),
      .p0_we(1'b0), .p1_we(1'b0),
      .p0_addr(8'h01), .p1_addr(8'h02),
      .p0_wdata(8'h00), .p1_wdata(8'h00),
      .p0_ack(b0_ack), .p1_ack(b1_ack),
      .p0_rdata(b0_rdata), .p1_rdata(b1_rdata),
      .mem_wbus(b_wbus), .mem_rbus(8'h3C),
      .c_memaddr(b_ma), .c_dataread(b_dr),
      .c_datawrite(b_dw),
      .busy(b_busy), .gnt_id(b_gnt)
   );

   // Simple memory: address latched from the bus, data written on strobe.
   always @(posedge clk) begin
      if (reset) begin
         env_a <= 8'h00;
         for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i * 7 + 3);
      end else begin
         if (c_memaddr) env_a <= mem_wbus;
         if (c_datawrite) env_mem[env_a] <= mem_wbus;
      end
   end
   assign mem_rbus = env_mem[env_a];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Predicts what the edge about to happen does, from the current inputs.
   task automatic model_edge();
      int   pa;
      logic e0, e1, w;
      k++;
      if (reset) begin
         m_have = 1'b0;
         m_last = 1'b1;
         m_rd0  = 8'h00;
         m_rd1  = 8'h00;
         for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
         return;
      end
      pa = m_have ? (k - 1 - m_g) : 99;
      if (pa >= 2) begin
         e0 = p0_req && !(pa == 2 && m_port == 1'b0);
         e1 = p1_req && !(pa == 2 && m_port == 1'b1);
         if (e0 || e1) begin
            w       = (e0 && e1) ? ~m_last : e1;
            m_last  = w;
            m_have  = 1'b1;
            m_g     = k;
            m_port  = w;
            m_we    = w ? p1_we    : p0_we;
            m_addr  = w ? p1_addr  : p0_addr;
            m_wdata = w ? p1_wdata : p0_wdata;
         end
      end
      if (m_have && (k - m_g) == 2) begin
         if (m_we)        ref_mem[m_addr] = m_wdata;
         else if (m_port) m_rd1 = ref_mem[m_addr];
         else             m_rd0 = ref_mem[m_addr];
      end
   endtask

   task automatic check_all();
      int         a;
      logic [2:0] ctl;
      logic [7:0] wb;
      logic [1:0] ack;
      a   = m_have ? (k - m_g) : 99;
      ctl = 3'b000;
      wb  = 8'h00;
      ack = 2'b00;
      if (a == 0) begin
         ctl = 3'b100;
         wb  = m_addr;
      end else if (a == 1) begin
         ctl = m_we ? 3'b001 : 3'b010;
         wb  = m_we ? m_wdata : 8'h00;
      end else if (a == 2) begin
         ack = m_port ? 2'b10 : 2'b01;
      end
      chk("ctrl", 32'({c_memaddr, c_dataread, c_datawrite}), 32'(ctl));
      chk("wbus", 32'(mem_wbus), 32'(wb));
      chk("busy", 32'(busy), 32'(a <= 2));
      chk("gnt_id", 32'(gnt_id), 32'((a <= 2) ? m_port : 1'b0));
      chk("ack", 32'({p1_ack, p0_ack}), 32'(ack));
      chk("p0_rdata", 32'(p0_rdata), 32'(m_rd0));
      chk("p1_rdata", 32'(p1_rdata), 32'(m_rd1));
      chk("onehot_a", 32'($onehot0({c_memaddr, c_dataread, c_datawrite})), 1);
      chk("onehot_b", 32'($onehot0({b_ma, b_dr, b_dw})), 1);
      chk("ackw_a", 32'(pa_ack & {p1_ack, p0_ack}), 0);
      chk("ackw_b", 32'(pb_ack & {b1_ack, b0_ack}), 0);
      pa_ack = {p1_ack, p0_ack};
      pb_ack = {b1_ack, b0_ack};
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      reset    = 1'b1;
      p0_req   = 1'b0; p1_req   = 1'b0;
      p0_we    = 1'b0; p1_we    = 1'b0;
      p0_addr  = 8'h00; p1_addr  = 8'h00;
      p0_wdata = 8'h00; p1_wdata = 8'h00;
      b0_req   = 1'b0; b1_req   = 1'b0;
      pa_ack   = 2'b00; pb_ack   = 2'b00;
      k = 0; m_have = 1'b0; m_g = 0; m_last = 1'b1;
      m_port = 1'b0; m_we = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
      m_rd0 = 8'h00; m_rd1 = 8'h00;
      repeat (2) step();

      // Both ports requesting continuously from reset.
      reset = 1'b0;
      p0_req = 1'b1; p1_req = 1'b1;
      p0_addr = 8'h05; p1_addr = 8'h06;
      b0_req = 1'b1; b1_req = 1'b1;
      nb0 = 0; nb1 = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("rr_seq", 32'({p1_ack, p0_ack}),
             32'((i % 3 != 0) ? 2'b00 :
                 (((i / 3) % 2) == 1) ? 2'b01 : 2'b10));
         chk("fixed_gnt", 32'(b_gnt & b_busy), 0);
         nb0 += int'(b0_ack);
         nb1 += int'(b1_ack);
      end
      chk("fixed_p0_acks", 32'(nb0 >= 3), 1);
      chk("fixed_p1_acks", 32'(nb1), 0);
      chk("fixed_rdata0", 32'(b0_rdata), 32'h3C);
      chk("fixed_rdata1", 32'(b1_rdata), 0);

      p0_req = 1'b0; p1_req = 1'b0;
      b0_req = 1'b0; b1_req = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      step();
      reset = 1'b0;

      // CPU write, then display read of the same location.
      p0_req = 1'b1; p0_we = 1'b1;
      p0_addr = 8'h10; p0_wdata = 8'hA5;
      step();
      chk("w_addr_phase", 32'({c_memaddr, mem_wbus}), 32'({1'b1, 8'h10}));
      p0_req = 1'b0; p0_we = 1'b0;
      p0_addr = 8'hEE; p0_wdata = 8'h11;
      step();
      chk("w_data_phase", 32'({c_datawrite, mem_wbus}), 32'({1'b1, 8'hA5}));
      step();
      chk("w_ack", 32'({p1_ack, p0_ack}), 32'(2'b01));
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h10;
      step();
      p1_req = 1'b0; p1_addr = 8'h77;
      step();
      step();
      chk("r_ack", 32'({p1_ack, p0_ack}), 32'(2'b10));
      chk("r_data", 32'(p1_rdata), 32'hA5);
      chk("r_other", 32'(p0_rdata), 0);
      step();

      // Reset landing in the ACCESS cycle of a write.
      p0_req = 1'b1; p0_we = 1'b1;
      p0_addr = 8'h20; p0_wdata = 8'h5A;
      step();
      p0_req = 1'b0;
      step();
      chk("abort_pre", 32'(c_datawrite), 1);
      reset = 1'b1;
      step();
      chk("abort_busy", 32'(busy), 0);
      chk("abort_dw", 32'(c_datawrite), 0);
      chk("abort_ack", 32'({p1_ack, p0_ack}), 0);
      reset = 1'b0;
      step();
      chk("abort_after", 32'({p1_ack, p0_ack, c_memaddr, c_dataread, c_datawrite}), 0);

      // Random traffic, including mid-flight input changes and resets.
      for (int i = 0; i < 600; i++) begin
         reset    = ($urandom_range(0, 63) == 0);
         p0_req   = ($urandom_range(0, 9) < 6);
         p1_req   = ($urandom_range(0, 9) < 6);
         p0_we    = 1'($urandom_range(0, 1));
         p1_we    = 1'($urandom_range(0, 1));
         p0_addr  = 8'($urandom_range(0, 15));
         p1_addr  = 8'($urandom_range(0, 15));
         p0_wdata = 8'($urandom);
         p1_wdata = 8'($urandom);
         b0_req   = 1'($urandom_range(0, 1));
         b1_req   = 1'($urandom_range(0, 1));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/datamem_arb.md
DATAMEM_ARB -- requirements
Module: datamem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter FIXED_PRIO, default 0: 0 = round-robin, 1 = port 0 always wins ties.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have ports p0_req / p1_req, input, 1 each, level access request (port 0 = CPU, port 1 = display scanner).
REQ-007 SHALL have ports p0_we / p1_we, input, 1 each: 1 = write, 0 = read.
REQ-008 SHALL have ports p0_addr / p1_addr, input, ADDR_W each, target address.
REQ-009 SHALL have ports p0_wdata / p1_wdata, input, DATA_W each, write data.
REQ-010 SHALL have ports p0_ack / p1_ack, output, 1 each, one-cycle completion pulse.
REQ-011 SHALL have ports p0_rdata / p1_rdata, output, DATA_W each, registered read data.
REQ-012 SHALL have port mem_wbus, output, DATA_W, value driven to the memory bus input.
REQ-013 SHALL have port mem_rbus, input, DATA_W, memory read bus.
REQ-014 SHALL have ports c_memaddr, c_dataread and c_datawrite, output, 1 each, memory controls.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-016 SHALL have port gnt_id, output, 1, index of the port currently owning the memory.

Function
REQ-017 SHALL implement the Moore FSM IDLE -> ADDR -> ACCESS -> DONE.
REQ-018 In IDLE and DONE, SHALL arbitrate: with any req high, latch the winner index, we, addr and wdata, then go to ADDR; with no req, go to IDLE.
REQ-019 ADDR: c_memaddr = 1, mem_wbus = latched addr (zero-extended to DATA_W); next state ACCESS.
REQ-020 ACCESS, write: c_datawrite = 1, mem_wbus = latched wdata.
REQ-021 ACCESS, read: c_dataread = 1, capture mem_rbus into the winner's rdata register at the end of the cycle.
REQ-022 ACCESS SHALL always go to DONE.
REQ-023 DONE: winner's ack = 1 for exactly one cycle; the other port's rdata is unchanged.
REQ-024 At most one of c_memaddr/c_dataread/c_datawrite SHALL be high in any cycle; all SHALL be 0 in IDLE and DONE.
REQ-025 mem_wbus SHALL be 0 whenever neither c_memaddr nor c_datawrite is asserted.
REQ-026 Latency: req sampled high in IDLE at cycle N -> ack at cycle N+3; back-to-back grants SHALL have 3-cycle spacing.
REQ-027 Round-robin (FIXED_PRIO=0): on a simultaneous request, the port not served last wins; the last-served register updates on each grant.
REQ-028 Arbitration in DONE SHALL exclude the port being acked in that cycle, preventing a duplicate access from a req not yet dropped.
REQ-029 A requester holding req high after ack SHALL be served again at the next eligible arbitration.
REQ-030 Port inputs SHALL be ignored after latching; changes during ADDR/ACCESS/DONE have no effect on the transaction in flight.
REQ-031 FIXED_PRIO=1 SHALL grant port 0 on every tie (port 1 may starve).
REQ-032 gnt_id SHALL hold the latched winner from ADDR through DONE, and 0 in IDLE.

Reset
REQ-033 reset SHALL force IDLE, all controls/acks/busy/gnt_id = 0, mem_wbus = 0, both rdata = 0, last-served = port 1.
REQ-034 Reset mid-transaction SHALL abort it with no ack and no further memory control.

Structure
REQ-035 Package datamem_arb_pkg SHALL hold the state enum (IDLE, ADDR, ACCESS, DONE) and the port-index constants PORT_CPU = 0 and PORT_DISP = 1.
REQ-036 The 2-way priority picker SHALL be sub-module datamem_arb_rr (inputs: reqs, last-served, mask, FIXED_PRIO; output: grant index and valid).

Verification
REQ-037 Port 0 write addr 0x10 data 0xA5 -> ADDR with mem_wbus = 0x10, then ACCESS with c_datawrite = 1 and mem_wbus = 0xA5, then p0_ack at +3.
REQ-038 Port 1 read addr 0x10 after REQ-037, memory model holding 0xA5 -> p1_rdata = 0xA5 coincident with p1_ack; p0_rdata unchanged.
REQ-039 Both req held continuously after reset, FIXED_PRIO=0 -> grants 0,1,0,1 at 3-cycle spacing, no double ack.
REQ-040 Same stimulus, FIXED_PRIO=1 -> grants 0,0,0; p1_ack never pulses.
REQ-041 Reset asserted during ACCESS of a write -> the next cycle shows IDLE, c_datawrite = 0, no ack.
REQ-042 Bench assertions on every cycle: memory controls one-hot-or-zero; each ack at most one cycle wide.
